// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to the receiver and transmitter.
package uart_pkg;

   localparam int unsigned BAUD_DIV = 2604;
   localparam int unsigned HALF_DIV = 1302;
   localparam logic [3:0]  BIT_CNT  = 4'd10;

   typedef enum logic {
      RX_IDLE    = 1'b0,
      RX_RECEIVE = 1'b1
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset to the idle level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Double-register the line to resolve metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/uart_rcv.sv
// UART receiver: 8N1 framing, mid-bit sampling, glitch rejection on the start bit, set/clear ready flag.
module uart_rcv #(
   parameter int unsigned BAUD_DIV = uart_pkg::BAUD_DIV,
   parameter int unsigned HALF_DIV = uart_pkg::HALF_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err
);

   import uart_pkg::rx_state_t;
   import uart_pkg::RX_IDLE;
   import uart_pkg::RX_RECEIVE;
   import uart_pkg::BIT_CNT;

   localparam logic [11:0] BAUD_LD = 12'(BAUD_DIV);
   localparam logic [11:0] HALF_LD = 12'(HALF_DIV);

   logic        rx_s;
   logic        rx_prev_r;
   rx_state_t   state_r;
   logic [8:0]  shift_r;
   logic [3:0]  bit_cnt_r;
   logic [11:0] baud_cnt_r;
   logic [7:0]  rx_data_r;
   logic        rdy_r;
   logic        frm_err_r;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   // Receive FSM: start detect, baud timing, bit shifting and result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= RX_IDLE;
         rx_prev_r  <= 1'b1;
         shift_r    <= 9'h1FF;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= BAUD_LD;
         rx_data_r  <= 8'h00;
         rdy_r      <= 1'b0;
         frm_err_r  <= 1'b0;
      end else begin
         rx_prev_r <= rx_s;
         case (state_r)
            RX_IDLE: begin
               if (rx_prev_r && !rx_s) begin
                  state_r    <= RX_RECEIVE;
                  baud_cnt_r <= HALF_LD;
                  bit_cnt_r  <= 4'd0;
                  rdy_r      <= 1'b0;
               end else if (clr_rdy) begin
                  rdy_r <= 1'b0;
               end
            end
            RX_RECEIVE: begin
               if (bit_cnt_r == BIT_CNT) begin
                  // shift_r now holds data[7:0] plus the stop bit in [8]; start bit shifted out
                  state_r    <= RX_IDLE;
                  baud_cnt_r <= BAUD_LD;
                  rx_data_r  <= shift_r[7:0];
                  frm_err_r  <= ~shift_r[8];
                  rdy_r      <= 1'b1;
               end else begin
                  if (clr_rdy) begin
                     rdy_r <= 1'b0;
                  end
                  if (baud_cnt_r == 12'd1) begin
                     baud_cnt_r <= BAUD_LD;
                     if ((bit_cnt_r == 4'd0) && rx_s) begin
                        state_r <= RX_IDLE;
                     end else begin
                        shift_r   <= {rx_s, shift_r[8:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                     end
                  end else begin
                     baud_cnt_r <= baud_cnt_r - 12'd1;
                  end
               end
            end
            default: begin
               state_r <= RX_IDLE;
            end
         endcase
      end
   end

   assign rx_data = rx_data_r;
   assign rdy     = rdy_r;
   assign frm_err = frm_err_r;

endmodule

// File: tb/tb_uart_rcv.sv
// Scoreboard bench for uart_rcv: frames are queued as they are sent, a monitor checks each rdy rise.
module tb_uart_rcv;

   localparam int B = 16;
   localparam int H = 8;
   // 2 sync stages + 1 edge-detect cycle + half bit + 9 bits + 1 completion cycle
   localparam int EXP_LAT = 2 + 1 + H + 9 * B + 1;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      int         start;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;

   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   exp_t       exp_q[$];
   logic [7:0] model_last = 8'h00;

   uart_rcv #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (B) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      e.data  = d;
      e.ferr  = ~stop;
      e.start = cyc;
      exp_q.push_back(e);
      model_last = d;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rx_data"}, rx_data, 8'h00);
      check({tag, "_rdy"}, rdy, 1'b0);
      check({tag, "_frm_err"}, frm_err, 1'b0);
   endtask

   // Monitor: every rising edge of rdy must match the oldest outstanding frame.
   initial begin
      logic rdy_q;
      exp_t e;
      int   lat;
      rdy_q = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rdy_q = 1'b0;
         end else begin
            if (rdy && !rdy_q) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_rdy: got rdy with rx_data %0h, expected no frame", rx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("mon_rx_data", rx_data, e.data);
                  check("mon_frm_err", frm_err, e.ferr);
                  lat = cyc - e.start;
                  vectors++;
                  if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
                     miscompares++;
                     $display("FAIL rdy_latency: got %0d clocks expected %0d +/-1", lat, EXP_LAT);
                  end
               end
            end
            rdy_q = rdy;
         end
      end
   end

   initial begin
      int n;
      rst_n   = 1'b0;
      rx      = 1'b1;
      clr_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Basic frame, good stop bit
      send_frame(8'hA5, 1'b1);
      send_bit(1'b1);
      check("a5_rdy", rdy, 1'b1);
      check("a5_rx_data", rx_data, 8'hA5);
      check("a5_frm_err", frm_err, 1'b0);

      // Framing error
      send_frame(8'h3C, 1'b0);
      send_bit(1'b1);
      check("3c_rx_data", rx_data, 8'h3C);
      check("3c_frm_err", frm_err, 1'b1);
      check("3c_rdy", rdy, 1'b1);

      // Back-to-back 0x00 then 0xFF with clr_rdy pulsed between them
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            send_bit(1'b1);
         end
         begin
            n = 0;
            while (!rdy && n < 12 * B) begin
               @(negedge clk);
               n++;
            end
            check("b2b_first_rdy", rdy, 1'b1);
            pulse_clr();
            check("b2b_clr_rdy", rdy, 1'b0);
         end
      join
      check("b2b_last_data", rx_data, 8'hFF);

      // Short low pulse on the line must be rejected
      pulse_clr();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 * B) @(negedge clk);
      check("glitch_rdy", rdy, 1'b0);
      check("glitch_rx_data", rx_data, model_last);

      // clr_rdy held across completion: set wins, then clears the next clock
      clr_rdy = 1'b1;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            n = 0;
            while (!rdy && n < 12 * B) begin
               @(negedge clk);
               n++;
            end
            check("setwins_rdy", rdy, 1'b1);
            @(negedge clk);
            check("clr_after_set_rdy", rdy, 1'b0);
         end
      join
      clr_rdy = 1'b0;
      send_bit(1'b1);

      // Reset during data bit 4 of 0x96, then a clean 0x5A
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(model_frame_bit(8'h96, i));
      rx = 1'b0;
      repeat (B / 2) @(negedge clk);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("midreset");
      rst_n = 1'b1;
      model_last = 8'h00;
      repeat (2 * B) @(negedge clk);
      check("postreset_rdy", rdy, 1'b0);
      send_frame(8'h5A, 1'b1);
      send_bit(1'b1);
      check("5a_rx_data", rx_data, 8'h5A);
      check("5a_frm_err", frm_err, 1'b0);

      // Randomized traffic: gaps, occasional framing errors, random clears, overruns
      for (int f = 0; f < 30; f++) begin
         logic [7:0] d;
         logic       stop;
         int         gap;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         gap  = stop ? $urandom_range(0, 20) : B + $urandom_range(0, 8);
         send_frame(d, stop);
         rx = 1'b1;
         if (gap > 0 && $urandom_range(0, 1) == 1) begin
            pulse_clr();
            gap--;
         end
         repeat (gap) @(negedge clk);
      end

      rx = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * B) begin
         @(negedge clk);
         n++;
      end
      check("drain_outstanding", exp_q.size(), 0);
      check("final_rx_data", rx_data, model_last);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   function automatic logic model_frame_bit(input logic [7:0] d, input int i);
      return d[i];
   endfunction

endmodule

// File: doc/uart_rcv.md
UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter: BAUD_DIV, 2604, clocks per bit (50 MHz / 19200).
REQ-002 Parameter: HALF_DIV, 1302, clocks from start-edge detect to mid-start-bit sample.
REQ-003 clk  input  1  system clock; all flops on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx  input  1  serial line, asynchronous to clk, idles high.
REQ-006 clr_rdy  input  1  one-cycle pulse from consumer that clears rdy.
REQ-007 rx_data  output  8  last received byte, LSB first on line.
REQ-008 rdy  output  1  byte available; set/reset flag.
REQ-009 frm_err  output  1  stop bit of last frame sampled low; valid while rdy high.

Function
REQ-010 rx SHALL pass through two flops before use; rx_s denotes the second flop output.
REQ-011 Start detect SHALL be rx_s previous=1, current=0, qualified only in IDLE.
REQ-012 States SHALL be IDLE and RECEIVE.
REQ-013 IDLE->RECEIVE on start detect: baud counter loaded with HALF_DIV, bit_cnt cleared to 0, rdy cleared that cycle.
REQ-014 In RECEIVE the baud counter SHALL decrement each clock; sample pulse when it reaches zero, then reload with BAUD_DIV.
REQ-015 On each sample: shift_reg(9 bits) <= {rx_s, shift_reg[8:1]}; bit_cnt increments by 1.
REQ-016 First sample (mid start bit) with rx_s=1 SHALL abort to IDLE, rdy unchanged, rx_data unchanged (glitch rejection).
REQ-017 After the 10th sample (bit_cnt reaches 10) SHALL return to IDLE next cycle; rx_data <= shift_reg[7:0], frm_err <= ~shift_reg[8], rdy set.
REQ-018 rdy SHALL rise 1302 + 9*2604 = 24738 clocks after the start-detect cycle (+/-1 clock).
REQ-019 rx_data and frm_err SHALL hold until the next completed frame.
REQ-020 clr_rdy SHALL clear rdy next clock; set and clr_rdy in same cycle: set wins.
REQ-021 A new start edge while rdy=1 SHALL clear rdy and begin reception (overrun: old byte lost, no flag).
REQ-022 Back-to-back frames (next start bit immediately after stop mid-sample) SHALL be received without loss.
REQ-023 Baud counter and bit_cnt SHALL hold (no toggling) in IDLE.

Reset
REQ-024 On rst_n low: state=IDLE, sync flops=1, shift_reg=9'h1FF, bit_cnt=0, baud counter=BAUD_DIV, rx_data=8'h00, rdy=0, frm_err=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, a frame is received only from the next genuine falling edge.

Structure
REQ-026 Shared package uart_pkg SHALL hold BAUD_DIV, HALF_DIV, bit-count constant 10 and the rx state encoding, also usable by the transmitter.
REQ-027 Sub-module uart_rx_sync SHALL implement the two-flop synchronizer (reset to 1).
REQ-028 Counters SHALL be 12 bits (baud) and 4 bits (bit_cnt).

Verification
REQ-029 Send 0xA5 at 2604 clk/bit, stop=1 -> rdy=1 at ~24738 clk after edge, rx_data=0xA5, frm_err=0.
REQ-030 Send 0x00 then 0xFF back-to-back, clr_rdy pulsed between -> rx_data 0x00 then 0xFF, both rdy pulses seen.
REQ-031 Drive rx low for 500 clocks then high -> state returns to IDLE, rdy stays 0, rx_data unchanged.
REQ-032 Send 0x3C with stop bit low -> rdy=1, rx_data=0x3C, frm_err=1.
REQ-033 clr_rdy asserted on completion cycle -> rdy=1; clr_rdy one cycle later -> rdy=0.
REQ-034 Assert rst_n low during bit 4 of 0x96, release, send 0x5A -> only 0x5A reported, frm_err=0.
